// File: rtl/dna_reader_gen.sv
// Reads the device DNA through DNA_PORT / DNA_PORTE2 and holds it in device_dna.
// One read takes DNA_WIDTH+2 cycles; requests arriving while busy are dropped.
module dna_reader_gen #(
  parameter int          DNA_WIDTH     = 57,
  parameter logic [95:0] SIM_DNA_VALUE = 96'h0,
  parameter bit          AUTO_READ     = 1'b1,
  parameter int          STARTUP_DELAY = 125,
  parameter logic [95:0] EXPECTED_DNA  = 96'h0,
  parameter bit          CHECK_EN      = 1'b0
) (
  input  logic        ap_clk,
  input  logic        areset,
  input  logic        read_req,
  output logic        busy,
  output logic        dna_valid,
  output logic        read_done,
  output logic [95:0] device_dna,
  output logic        dna_match
);

  localparam logic [DNA_WIDTH-1:0] SIM_W      = SIM_DNA_VALUE[DNA_WIDTH-1:0];
  localparam logic [DNA_WIDTH-1:0] EXP_W      = EXPECTED_DNA[DNA_WIDTH-1:0];
  localparam logic [15:0]          WAIT_LAST  = 16'(STARTUP_DELAY - 1);
  localparam logic [6:0]           SHIFT_LAST = 7'(DNA_WIDTH - 1);

  generate
    if (DNA_WIDTH != 57 && DNA_WIDTH != 96) begin : g_bad_width
      $error("dna_reader_gen: DNA_WIDTH must be 57 or 96");
    end
    if (STARTUP_DELAY < 1 || STARTUP_DELAY > 65535) begin : g_bad_delay
      $error("dna_reader_gen: STARTUP_DELAY must be in 1..65535");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                 state_q;
  logic                   auto_pend_q;
  logic [15:0]            wait_cnt_q;
  logic [6:0]             bit_cnt_q;
  // Bit 0 of the shift window is always shifted out before use, so only the upper bits are kept.
  logic [DNA_WIDTH-2:0]   cap_q;
  logic [DNA_WIDTH-1:0]   cap_d;
  logic [DNA_WIDTH-1:0]   dna_q;
  logic                   busy_q;
  logic                   valid_q;
  logic                   done_q;
  logic                   match_q;
  logic                   prim_read_q;
  logic                   prim_shift_q;
  logic                   prim_dout;

  assign cap_d = {prim_dout, cap_q};

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      auto_pend_q  <= AUTO_READ;
      wait_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      cap_q        <= '0;
      dna_q        <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      prim_read_q  <= 1'b0;
      prim_shift_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (auto_pend_q) begin
            auto_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end else if (read_req) begin
            busy_q      <= 1'b1;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            prim_read_q <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q  <= '0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            prim_read_q <= 1'b1;
            state_q     <= ST_LOAD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        ST_LOAD: begin
          prim_read_q  <= 1'b0;
          prim_shift_q <= 1'b1;
          bit_cnt_q    <= '0;
          state_q      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          cap_q <= cap_d[DNA_WIDTH-1:1];
          if (bit_cnt_q == SHIFT_LAST) begin
            bit_cnt_q    <= '0;
            prim_shift_q <= 1'b0;
            busy_q       <= 1'b0;
            dna_q        <= cap_d;
            valid_q      <= 1'b1;
            done_q       <= 1'b1;
            match_q      <= CHECK_EN && (cap_d == EXP_W);
            state_q      <= ST_DONE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 7'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SYNTHESIS
  generate
    if (DNA_WIDTH == 57) begin : g_dna_port
      DNA_PORT #(.SIM_DNA_VALUE(SIM_DNA_VALUE[56:0])) u_dna (
        .CLK(ap_clk), .DIN(1'b0), .READ(prim_read_q), .SHIFT(prim_shift_q), .DOUT(prim_dout)
      );
    end else begin : g_dna_porte2
      DNA_PORTE2 #(.SIM_DNA_VALUE(SIM_DNA_VALUE)) u_dna (
        .CLK(ap_clk), .DIN(1'b0), .READ(prim_read_q), .SHIFT(prim_shift_q), .DOUT(prim_dout)
      );
    end
  endgenerate
`else
  // Behavioural stand-in for the primitive: READ loads, SHIFT moves LSB-first towards DOUT.
  logic [DNA_WIDTH-1:0] model_sr_q;
  always_ff @(posedge ap_clk) begin
    if (prim_read_q) begin
      model_sr_q <= SIM_W;
    end else if (prim_shift_q) begin
      model_sr_q <= {1'b0, model_sr_q[DNA_WIDTH-1:1]};
    end
  end
  assign prim_dout = model_sr_q[0];
`endif

  assign busy       = busy_q;
  assign dna_valid  = valid_q;
  assign read_done  = done_q;
  assign device_dna = 96'(dna_q);
  assign dna_match  = match_q;

endmodule

// File: tb/tb_dna_reader_gen.sv
module tb_dna_reader_gen;

  localparam logic [95:0] SIM57 = 96'h1A5A5A5A5A5A5A5;
  localparam logic [95:0] SIM96 = 96'h4002000001167BC804206405;
  localparam logic [95:0] EXP96 = 96'h4002000001167BC804206404;

  logic        clk;
  logic        rst57, req57, busy57, valid57, done57, match57;
  logic [95:0] dna57;
  logic        rst96, req96, busy96, valid96, done96, match96;
  logic [95:0] dna96;

  int checks;
  int failures;

  dna_reader_gen #(
    .DNA_WIDTH(57), .SIM_DNA_VALUE(SIM57), .AUTO_READ(1'b1), .STARTUP_DELAY(4),
    .EXPECTED_DNA(SIM57), .CHECK_EN(1'b1)
  ) u57 (
    .ap_clk(clk), .areset(rst57), .read_req(req57), .busy(busy57), .dna_valid(valid57),
    .read_done(done57), .device_dna(dna57), .dna_match(match57)
  );

  dna_reader_gen #(
    .DNA_WIDTH(96), .SIM_DNA_VALUE(SIM96), .AUTO_READ(1'b0), .STARTUP_DELAY(125),
    .EXPECTED_DNA(EXP96), .CHECK_EN(1'b1)
  ) u96 (
    .ap_clk(clk), .areset(rst96), .read_req(req96), .busy(busy96), .dna_valid(valid96),
    .read_done(done96), .device_dna(dna96), .dna_match(match96)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({busy57, valid57, done57, match57} !== 4'b0000) begin
      failures++;
      $display("FAIL reset57_flags: got %b expected 0000", {busy57, valid57, done57, match57});
    end
    checks++;
    if (dna57 !== 96'h0) begin
      failures++;
      $display("FAIL reset57_dna: got %h expected 0", dna57);
    end
    checks++;
    if ({busy96, valid96, done96, match96} !== 4'b0000 || dna96 !== 96'h0) begin
      failures++;
      $display("FAIL reset96_outputs: got %b/%h expected 0000/0",
               {busy96, valid96, done96, match96}, dna96);
    end
  endtask

  // Auto read after reset release; read_req during WAIT must be ignored.
  task automatic test_auto_read(input string tag);
    int read_at, done_at, done_cnt;
    logic [95:0] dna_done, dna_pre;
    logic match_done, match_pre, valid_pre, busy1;
    read_at = -1; done_at = -1; done_cnt = 0;
    dna_done = '0; dna_pre = '1; match_done = 1'b0; match_pre = 1'b1; valid_pre = 1'b1;
    busy1 = 1'b0;
    rst57 = 1'b0;
    checks++;
    if (busy57 !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_cycle0: got %b expected 0", tag, busy57);
    end
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (c == 1) busy1 = busy57;
      if (u57.prim_read_q === 1'b1 && read_at < 0) read_at = c;
      if (done57 === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c; dna_done = dna57; match_done = match57;
        end
      end
      if (c == 62) begin
        dna_pre = dna57; match_pre = match57; valid_pre = valid57;
      end
      req57 = (c == 2);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_wait: got %b expected 1", tag, busy1);
    end
    checks++;
    if (read_at != 5) begin
      failures++;
      $display("FAIL %s_read_cycle: got %0d expected 5", tag, read_at);
    end
    checks++;
    if (done_at != 63 || done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done_cycle: got %0d (pulses %0d) expected 63 (pulses 1)", tag, done_at, done_cnt);
    end
    checks++;
    if (dna_done !== SIM57) begin
      failures++;
      $display("FAIL %s_dna: got %h expected %h", tag, dna_done, SIM57);
    end
    checks++;
    if (match_done !== 1'b1 || match_pre !== 1'b0 || valid_pre !== 1'b0) begin
      failures++;
      $display("FAIL %s_match_edge: got match=%b pre_match=%b pre_valid=%b expected 1 0 0",
               tag, match_done, match_pre, valid_pre);
    end
    checks++;
    if (busy57 !== 1'b0 || valid57 !== 1'b1) begin
      failures++;
      $display("FAIL %s_final_state: got busy=%b valid=%b expected 0 1", tag, busy57, valid57);
    end
  endtask

  // One manual read on the 96-bit instance; returns first dna_valid cycle and values seen.
  task automatic run_read96(output int valid_at, output int done_cnt, output logic [95:0] dna_v,
                            output logic match_v);
    valid_at = -1; done_cnt = 0; dna_v = '0; match_v = 1'b1;
    req96 = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      tick();
      req96 = 1'b0;
      if (done96 === 1'b1) done_cnt++;
      if (valid96 === 1'b1 && valid_at < 0) begin
        valid_at = c; dna_v = dna96; match_v = match96;
      end
    end
  endtask

  task automatic test_manual_read();
    int valid_at, done_cnt, busy_seen;
    logic [95:0] dna_v;
    logic match_v;
    busy_seen = 0;
    rst96 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy96 !== 1'b0 || valid96 !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL manual_no_autoread: got %0d busy/valid cycles expected 0", busy_seen);
    end
    run_read96(valid_at, done_cnt, dna_v, match_v);
    checks++;
    if (valid_at != 98 || done_cnt != 1) begin
      failures++;
      $display("FAIL manual_latency: got %0d (pulses %0d) expected 98 (pulses 1)", valid_at, done_cnt);
    end
    checks++;
    if (dna_v !== SIM96) begin
      failures++;
      $display("FAIL manual_dna: got %h expected %h", dna_v, SIM96);
    end
    checks++;
    if (match_v !== 1'b0) begin
      failures++;
      $display("FAIL manual_mismatch_bit0: got %b expected 0", match_v);
    end
  endtask

  task automatic test_back_to_back();
    int reads, done_cnt, done_at, dna_changed;
    logic busy10, valid1;
    reads = 0; done_cnt = 0; done_at = -1; dna_changed = 0; busy10 = 1'b0; valid1 = 1'b1;
    req96 = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (u96.prim_read_q === 1'b1) reads++;
      if (done96 === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (busy96 === 1'b1 && dna96 !== SIM96) dna_changed++;
      if (c == 1) valid1 = valid96;
      if (c == 10) busy10 = busy96;
      req96 = (c == 10);
    end
    checks++;
    if (reads != 1 || done_cnt != 1 || done_at != 98) begin
      failures++;
      $display("FAIL b2b_single_read: got loads=%0d done=%0d at %0d expected 1 1 at 98",
               reads, done_cnt, done_at);
    end
    checks++;
    if (dna_changed != 0) begin
      failures++;
      $display("FAIL b2b_dna_hold: got %0d changed cycles expected 0", dna_changed);
    end
    checks++;
    if (busy10 !== 1'b1 || valid1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_flags: got busy10=%b valid1=%b expected 1 0", busy10, valid1);
    end
    checks++;
    if (busy96 !== 1'b0 || valid96 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: got busy=%b valid=%b expected 0 1", busy96, valid96);
    end
  endtask

  task automatic test_reset_mid_shift();
    int valid_at, done_cnt, busy_seen;
    logic [95:0] dna_v;
    logic match_v, shifting;
    busy_seen = 0; shifting = 1'b0;
    req96 = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      req96 = 1'b0;
      if (c == 22) shifting = u96.prim_shift_q;
    end
    rst96 = 1'b1;
    tick();
    rst96 = 1'b0;
    checks++;
    if (shifting !== 1'b1) begin
      failures++;
      $display("FAIL midshift_in_shift: got %b expected 1", shifting);
    end
    checks++;
    if ({busy96, valid96, done96, match96} !== 4'b0000 || dna96 !== 96'h0) begin
      failures++;
      $display("FAIL midshift_outputs: got %b/%h expected 0000/0",
               {busy96, valid96, done96, match96}, dna96);
    end
    checks++;
    if ({u96.prim_read_q, u96.prim_shift_q} !== 2'b00) begin
      failures++;
      $display("FAIL midshift_prim: got %b expected 00", {u96.prim_read_q, u96.prim_shift_q});
    end
    for (int c = 0; c < 120; c++) begin
      tick();
      if (busy96 !== 1'b0 || valid96 !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL midshift_no_restart: got %0d busy/valid cycles expected 0", busy_seen);
    end
    run_read96(valid_at, done_cnt, dna_v, match_v);
    checks++;
    if (valid_at != 98 || dna_v !== SIM96) begin
      failures++;
      $display("FAIL midshift_reread: got %0d/%h expected 98/%h", valid_at, dna_v, SIM96);
    end
  endtask

  task automatic test_auto_restart();
    rst57 = 1'b1;
    tick();
    checks++;
    if ({busy57, valid57, match57} !== 3'b000 || dna57 !== 96'h0) begin
      failures++;
      $display("FAIL restart_cleared: got %b/%h expected 000/0", {busy57, valid57, match57}, dna57);
    end
    test_auto_read("restart");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst57 = 1'b1; req57 = 1'b0;
    rst96 = 1'b1; req96 = 1'b0;
    test_reset();
    test_auto_read("auto57");
    test_manual_read();
    test_back_to_back();
    test_reset_mid_shift();
    test_auto_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dna_reader_gen.md
DNA_READER_GEN -- requirements
Module: dna_reader_gen

Interface
REQ-001 SHALL provide parameter DNA_WIDTH, default 57: device DNA length; legal values 57 (DNA_PORT) and 96 (DNA_PORTE2); any other value SHALL fail elaboration.
REQ-002 SHALL provide parameter SIM_DNA_VALUE, default 96'h0: passed to the primitive, truncated to DNA_WIDTH bits.
REQ-003 SHALL provide parameter AUTO_READ, default 1: 1 = start one read automatically after reset; 0 = read only on request.
REQ-004 SHALL provide parameter STARTUP_DELAY, default 125: cycles waited after reset release before the automatic read, range 1..65535.
REQ-005 SHALL provide parameter EXPECTED_DNA, default 96'h0: value used for the match check.
REQ-006 SHALL provide parameter CHECK_EN, default 0: 1 enables the match output; 0 ties it low.
REQ-007 SHALL provide port ap_clk, input, 1 bit: sole clock; also drives the primitive CLK.
REQ-008 SHALL provide port areset, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL provide port read_req, input, 1 bit: single-cycle read request.
REQ-010 SHALL provide port busy, output, 1 bit: a read is in progress.
REQ-011 SHALL provide port dna_valid, output, 1 bit: device_dna holds a completed read.
REQ-012 SHALL provide port read_done, output, 1 bit: one-cycle pulse when each read completes.
REQ-013 SHALL provide port device_dna, output, 96 bits: captured DNA, zero-extended above DNA_WIDTH.
REQ-014 SHALL provide port dna_match, output, 1 bit: device_dna[DNA_WIDTH-1:0] equals EXPECTED_DNA[DNA_WIDTH-1:0].

Function
REQ-015 SHALL instantiate DNA_PORT with DIN=0 when DNA_WIDTH=57, and DNA_PORTE2 with DIN=0 when DNA_WIDTH=96.
REQ-016 SHALL implement FSM states IDLE, WAIT, LOAD, SHIFT, DONE.
REQ-017 SHALL leave reset in WAIT when AUTO_READ=1 and in IDLE when AUTO_READ=0.
REQ-018 In WAIT, the state SHALL count STARTUP_DELAY cycles, then go to LOAD; read_req SHALL be ignored in WAIT.
REQ-019 In IDLE or DONE, read_req=1 SHALL move the FSM to LOAD on the next cycle.
REQ-020 LOAD SHALL last exactly one cycle with primitive READ=1 and SHIFT=0, then go to SHIFT.
REQ-021 SHIFT SHALL last exactly DNA_WIDTH cycles with SHIFT=1 and READ=0; a 7-bit counter SHALL run from 0 to DNA_WIDTH-1, then the FSM SHALL go to DONE.
REQ-022 On each SHIFT cycle, the capture register SHALL shift right by one with DOUT inserted at bit DNA_WIDTH-1, so that the first sampled bit ends at bit 0.
REQ-023 On the SHIFT-to-DONE transition, the capture register SHALL be copied into device_dna in one update; device_dna SHALL otherwise hold its value, including the old value during a re-read.
REQ-024 busy SHALL be 1 in WAIT, LOAD and SHIFT, and 0 otherwise.
REQ-025 dna_valid SHALL go low on entry to LOAD and go high on the first DONE cycle.
REQ-026 read_done SHALL pulse high for one cycle, coincident with the first DONE cycle.
REQ-027 read_req while busy=1 SHALL be dropped and never queued.
REQ-028 Latency SHALL be: read_req at cycle 0 -> READ at cycle 1 -> SHIFT at cycles 2..DNA_WIDTH+1 -> dna_valid and read_done at cycle DNA_WIDTH+2.
REQ-029 dna_match SHALL be registered, update in the same cycle as device_dna, and be 0 whenever dna_valid=0 or CHECK_EN=0.
REQ-030 The design SHALL meet timing with the primitive clocked at ap_clk, and ap_clk frequency SHALL stay within the primitive maximum; no internal clock division.

Reset
REQ-031 On areset=1, the block SHALL set busy=0, dna_valid=0, read_done=0, dna_match=0 and device_dna=0, clear the capture register and all counters, and deassert primitive READ and SHIFT.
REQ-032 Reset asserted mid-SHIFT SHALL abort the read with no partial update of device_dna; on release, the FSM SHALL follow REQ-017.

Verification
REQ-033 DNA_WIDTH=57, AUTO_READ=1, STARTUP_DELAY=4, SIM_DNA_VALUE=57'h1A5A5A5A5A5A5A5 -> release reset; READ pulses at cycle 5; device_dna=96'h1A5A5A5A5A5A5A5 and read_done pulses at cycle 63.
REQ-034 DNA_WIDTH=96, AUTO_READ=0, SIM_DNA_VALUE=96'h4002000001167BC804206405 -> read_req pulse -> dna_valid at +98 cycles; device_dna equals SIM_DNA_VALUE.
REQ-035 From DONE, issue read_req; pulse read_req again 10 cycles later -> exactly one read; device_dna unchanged while busy; second request dropped.
REQ-036 Assert areset at SHIFT cycle 20 -> all outputs 0 next cycle; with AUTO_READ=0, no read until read_req.
REQ-037 CHECK_EN=1, EXPECTED_DNA equal to and then differing from SIM_DNA_VALUE in bit 0 -> dna_match=1 and 0 respectively, rising together with dna_valid.
REQ-038 A DNA_WIDTH=64 build -> elaboration error.
